// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the EX/MEM skid pipeline stage.
//   - LD_TYPE_RST_DFLT / ST_TYPE_RST_DFLT : default bubble values for the
//     load/store type fields
//   - skid_state_t : occupancy state of the 2-entry skid buffer. The encoding
//     equals the number of held entries, so the state register doubles as the
//     occupancy output.
//   - ex_mem_payload_t : payload layout at the default parameter widths.
//     Fields run MSB to LSB in the same order the top level concatenates them.
//   - payload_width() : payload width for any parameter set.
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam logic [2:0] LD_TYPE_RST_DFLT = 3'b111;
    localparam logic [1:0] ST_TYPE_RST_DFLT = 2'b11;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] op2;
        logic        memory_write;
        logic [2:0]  load_type;
        logic [1:0]  store_type;
        logic        wb_load;
        logic        wb_reg_file;
        logic [4:0]  rd;
    } ex_mem_payload_t;

    function automatic int payload_width(input int xlen, input int rd_w,
                                         input int ld_w, input int st_w);
        return 2 * xlen + rd_w + ld_w + st_w + 3;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
// Generic WIDTH-bit pipeline register with a valid/ready handshake on both
// sides. With SKID=1 it holds up to two entries and o_ready is a flop output.
// With SKID=0 it holds one entry and o_ready is combinational.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   i_flush              drop all held entries (wins over accept/drain)
//   i_valid/o_ready      upstream handshake, i_data payload in
//   o_valid/i_ready      downstream handshake, o_data = head entry
//   o_occupancy          number of held entries (0..2), registered
// ---------------------------------------------------------------------------
// state | meaning
// EMPTY | nothing held, o_valid = 0
// HALF  | head register valid, skid register free
// FULL  | head and skid registers valid, upstream stalled (SKID=1 only)
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int WIDTH = 8,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_occupancy
);
    import pipeline_pkg::*;

    skid_state_t      r_state;
    skid_state_t      w_next_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_accept;
    logic             w_drain;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    assign o_valid     = (r_state != EMPTY);
    assign w_accept    = i_valid & o_ready;
    assign w_drain     = o_valid & i_ready;
    assign o_data      = r_main;
    assign o_occupancy = r_state;

    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_next_state   = HALF;
                        w_load_main_in = 1'b1;
                    end
                end
                HALF: begin
                    if (w_accept && w_drain) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        // Only reachable with the skid entry present; without
                        // it ready is low whenever the head is stalled.
                        if (SKID != 0) begin
                            w_next_state = FULL;
                            w_load_skid  = 1'b1;
                        end
                    end else if (w_drain) begin
                        w_next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (w_drain) begin
                        w_next_state     = HALF;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_next_state = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Data registers are deliberately untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
        end else if (w_load_main_in) begin
            r_main <= i_data;
        end else if (w_load_main_skid) begin
            r_main <= r_skid;
        end
    end

    // With SKID=0 w_load_skid is constant 0 and this register disappears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid <= '0;
        end else if (w_load_skid) begin
            r_skid <= i_data;
        end
    end

    generate
        if (SKID != 0) begin : g_reg_ready
            logic r_ready;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ready <= 1'b1;
                end else begin
                    r_ready <= (w_next_state != FULL);
                end
            end
            assign o_ready = r_ready;
        end else begin : g_comb_ready
            assign o_ready = ~o_valid | i_ready;
        end
    endgenerate

endmodule

// File: rtl/ex_mem_skid_pipeline.sv
// ---------------------------------------------------------------------------
// ex_mem_skid_pipeline
// EX/MEM pipeline stage with valid/ready on both sides, optional 2-entry skid
// buffer (SKID=1 keeps ex_ready registered), flush-to-bubble and x0 write
// suppression.
// Ports:
//   clk, rst_n, flush               clock, async active-low reset, kill held
//   ex_valid / ex_ready             EX-side handshake
//   ex_*                            instruction fields from execute
//   mem_valid / mem_ready           MEM-side handshake on the head entry
//   mem_*                           head fields; strobes gated by mem_valid,
//                                   type fields forced to bubble values
//   occupancy                       entries held (0..2)
// ---------------------------------------------------------------------------
module ex_mem_skid_pipeline
    import pipeline_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              RD_W        = 5,
    parameter int              LD_W        = 3,
    parameter int              ST_W        = 2,
    parameter int              SKID        = 1,
    parameter logic [LD_W-1:0] LD_TYPE_RST = LD_TYPE_RST_DFLT,
    parameter logic [ST_W-1:0] ST_TYPE_RST = ST_TYPE_RST_DFLT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] ex_op2_selected,
    input  logic            ex_memory_write,
    input  logic [LD_W-1:0] ex_memory_load_type,
    input  logic [ST_W-1:0] ex_memory_store_type,
    input  logic            ex_wb_load,
    input  logic            ex_wb_reg_file,
    input  logic [RD_W-1:0] ex_wb_rd,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] mem_op2_selected,
    output logic            mem_memory_write,
    output logic            mem_memory_read,
    output logic [LD_W-1:0] mem_memory_load_type,
    output logic [ST_W-1:0] mem_memory_store_type,
    output logic            mem_wb_load,
    output logic            mem_wb_reg_file,
    output logic [RD_W-1:0] mem_wb_rd,
    output logic [1:0]      occupancy
);
    localparam int PW = payload_width(XLEN, RD_W, LD_W, ST_W);

    logic [PW-1:0]   w_in_payload;
    logic [PW-1:0]   w_out_payload;
    logic [XLEN-1:0] w_result;
    logic [XLEN-1:0] w_op2;
    logic            w_write;
    logic [LD_W-1:0] w_ld_type;
    logic [ST_W-1:0] w_st_type;
    logic            w_wb_load;
    logic            w_wb_reg_file;
    logic [RD_W-1:0] w_rd;

    assign w_in_payload = {ex_result, ex_op2_selected, ex_memory_write,
                           ex_memory_load_type, ex_memory_store_type,
                           ex_wb_load, ex_wb_reg_file, ex_wb_rd};

    pipe_skid_reg #(
        .WIDTH (PW),
        .SKID  (SKID)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (flush),
        .i_valid     (ex_valid),
        .o_ready     (ex_ready),
        .i_data      (w_in_payload),
        .o_valid     (mem_valid),
        .i_ready     (mem_ready),
        .o_data      (w_out_payload),
        .o_occupancy (occupancy)
    );

    assign {w_result, w_op2, w_write, w_ld_type, w_st_type,
            w_wb_load, w_wb_reg_file, w_rd} = w_out_payload;

    // Data fields pass through ungated so they keep their last value in a
    // bubble; only strobes and type fields see mem_valid.
    assign mem_result            = w_result;
    assign mem_op2_selected      = w_op2;
    assign mem_wb_rd             = w_rd;
    assign mem_memory_write      = w_write & mem_valid;
    assign mem_memory_read       = w_wb_load & mem_valid;
    assign mem_wb_load           = w_wb_load & mem_valid;
    assign mem_wb_reg_file       = w_wb_reg_file & mem_valid & (w_rd != '0);
    assign mem_memory_load_type  = mem_valid ? w_ld_type : LD_TYPE_RST;
    assign mem_memory_store_type = mem_valid ? w_st_type : ST_TYPE_RST;

endmodule

// File: tb/tb_ex_mem_skid_pipeline.sv
module tb_ex_mem_skid_pipeline;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] op2;
        logic        wr;
        logic [2:0]  ld;
        logic [1:0]  st;
        logic        wbl;
        logic        wbr;
        logic [4:0]  rd;
    } item_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  flush = 1'b0;
    logic  ex_valid = 1'b0;
    logic  mem_ready = 1'b0;
    item_t ex_item = '0;

    always #5 clk = ~clk;

    // Outputs of the SKID=1 instance (suffix _1) and the SKID=0 instance (_0)
    logic        ex_ready_1, mem_valid_1, mem_write_1, mem_read_1, mem_wbl_1, mem_wbr_1;
    logic [31:0] mem_result_1, mem_op2_1;
    logic [2:0]  mem_ld_1;
    logic [1:0]  mem_st_1, occ_1;
    logic [4:0]  mem_rd_1;
    logic        ex_ready_0, mem_valid_0, mem_write_0, mem_read_0, mem_wbl_0, mem_wbr_0;
    logic [31:0] mem_result_0, mem_op2_0;
    logic [2:0]  mem_ld_0;
    logic [1:0]  mem_st_0, occ_0;
    logic [4:0]  mem_rd_0;

    ex_mem_skid_pipeline #(.SKID(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready_1),
        .ex_result(ex_item.result), .ex_op2_selected(ex_item.op2),
        .ex_memory_write(ex_item.wr), .ex_memory_load_type(ex_item.ld),
        .ex_memory_store_type(ex_item.st), .ex_wb_load(ex_item.wbl),
        .ex_wb_reg_file(ex_item.wbr), .ex_wb_rd(ex_item.rd),
        .mem_valid(mem_valid_1), .mem_ready(mem_ready),
        .mem_result(mem_result_1), .mem_op2_selected(mem_op2_1),
        .mem_memory_write(mem_write_1), .mem_memory_read(mem_read_1),
        .mem_memory_load_type(mem_ld_1), .mem_memory_store_type(mem_st_1),
        .mem_wb_load(mem_wbl_1), .mem_wb_reg_file(mem_wbr_1),
        .mem_wb_rd(mem_rd_1), .occupancy(occ_1)
    );

    ex_mem_skid_pipeline #(.SKID(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready_0),
        .ex_result(ex_item.result), .ex_op2_selected(ex_item.op2),
        .ex_memory_write(ex_item.wr), .ex_memory_load_type(ex_item.ld),
        .ex_memory_store_type(ex_item.st), .ex_wb_load(ex_item.wbl),
        .ex_wb_reg_file(ex_item.wbr), .ex_wb_rd(ex_item.rd),
        .mem_valid(mem_valid_0), .mem_ready(mem_ready),
        .mem_result(mem_result_0), .mem_op2_selected(mem_op2_0),
        .mem_memory_write(mem_write_0), .mem_memory_read(mem_read_0),
        .mem_memory_load_type(mem_ld_0), .mem_memory_store_type(mem_st_0),
        .mem_wb_load(mem_wbl_0), .mem_wb_reg_file(mem_wbr_0),
        .mem_wb_rd(mem_rd_0), .occupancy(occ_0)
    );

    int    checks = 0;
    int    failures = 0;
    // Reference model: one FIFO of accepted instructions per instance.
    item_t exp_q[2][$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare one instance against its FIFO: head = oldest accepted entry.
    task automatic mon(input int d, input logic v, input logic rdy, input logic [1:0] occ,
                       input logic [31:0] res, input logic [31:0] op2, input logic wr,
                       input logic rds, input logic [2:0] ld, input logic [1:0] st,
                       input logic wbl, input logic wbr, input logic [4:0] rd);
        int    n;
        item_t p;
        string t;
        logic  er;
        n = exp_q[d].size();
        t = (d == 1) ? "skid1" : "skid0";
        if (d == 1) er = (n < 2);
        else        er = (n == 0) || mem_ready;
        chk({t, ".mem_valid"}, 64'(v), 64'(n > 0));
        chk({t, ".occupancy"}, 64'(occ), 64'(n));
        chk({t, ".ex_ready"}, 64'(rdy), 64'(er));
        if (n > 0) begin
            p = exp_q[d][0];
            chk({t, ".mem_result"}, 64'(res), 64'(p.result));
            chk({t, ".mem_op2"}, 64'(op2), 64'(p.op2));
            chk({t, ".mem_rd"}, 64'(rd), 64'(p.rd));
            chk({t, ".load_type"}, 64'(ld), 64'(p.ld));
            chk({t, ".store_type"}, 64'(st), 64'(p.st));
            chk({t, ".mem_write"}, 64'(wr), 64'(p.wr));
            chk({t, ".mem_read"}, 64'(rds), 64'(p.wbl));
            chk({t, ".wb_load"}, 64'(wbl), 64'(p.wbl));
            chk({t, ".wb_reg_file"}, 64'(wbr), 64'(p.wbr && (p.rd != 5'd0)));
        end else begin
            chk({t, ".bubble_load_type"}, 64'(ld), 64'(3'b111));
            chk({t, ".bubble_store_type"}, 64'(st), 64'(2'b11));
            chk({t, ".bubble_strobes"}, 64'({wr, rds, wbl, wbr}), 64'(0));
        end
    endtask

    // Monitor: 2 time units after each rising edge, then retire the head if
    // MEM is taking it at the coming edge.
    always @(posedge clk) begin
        #2;
        mon(1, mem_valid_1, ex_ready_1, occ_1, mem_result_1, mem_op2_1, mem_write_1,
            mem_read_1, mem_ld_1, mem_st_1, mem_wbl_1, mem_wbr_1, mem_rd_1);
        mon(0, mem_valid_0, ex_ready_0, occ_0, mem_result_0, mem_op2_0, mem_write_0,
            mem_read_0, mem_ld_0, mem_st_0, mem_wbl_0, mem_wbr_0, mem_rd_0);
        if (rst_n && mem_ready && !flush) begin
            for (int d = 0; d < 2; d++)
                if (exp_q[d].size() > 0) void'(exp_q[d].pop_front());
        end
    end

    // Drive one cycle of stimulus and record what each instance will accept.
    task automatic cycle(input logic v, input item_t it, input logic mr, input logic fl);
        @(posedge clk);
        #1;
        ex_valid  = v;
        ex_item   = it;
        mem_ready = mr;
        flush     = fl;
        #2;
        if (rst_n) begin
            if (fl) begin
                exp_q[0].delete();
                exp_q[1].delete();
            end else begin
                if (v && ex_ready_1) exp_q[1].push_back(it);
                if (v && ex_ready_0) exp_q[0].push_back(it);
            end
        end
    endtask

    function automatic item_t mk(input logic [31:0] res, input logic wr, input logic wbl,
                                 input logic wbr, input logic [4:0] rd);
        item_t p;
        p.result = res;
        p.op2    = res ^ 32'h5A5A_0000;
        p.wr     = wr;
        p.ld     = 3'd2;
        p.st     = 2'd1;
        p.wbl    = wbl;
        p.wbr    = wbr;
        p.rd     = rd;
        return p;
    endfunction

    function automatic item_t rnd_item();
        item_t p;
        p.result = $urandom;
        p.op2    = $urandom;
        p.wr     = 1'($urandom_range(0, 1));
        p.ld     = 3'($urandom_range(0, 7));
        p.st     = 2'($urandom_range(0, 3));
        p.wbl    = 1'($urandom_range(0, 1));
        p.wbr    = 1'($urandom_range(0, 1));
        p.rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        return p;
    endfunction

    item_t idle;
    logic  mr_r;

    initial begin
        idle = '0;
        // Reset
        repeat (3) cycle(1'b0, idle, 1'b0, 1'b0);
        chk("reset.mem_result", 64'(mem_result_1), 64'(0));
        chk("reset.mem_op2", 64'(mem_op2_1), 64'(0));
        chk("reset.mem_rd", 64'(mem_rd_1), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming at full throughput
        cycle(1'b1, mk(32'h10, 1'b0, 1'b0, 1'b1, 5'd3), 1'b1, 1'b0);
        cycle(1'b1, mk(32'h20, 1'b0, 1'b1, 1'b1, 5'd4), 1'b1, 1'b0);
        cycle(1'b1, mk(32'h30, 1'b1, 1'b0, 1'b0, 5'd6), 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);

        // Backpressure into the skid entry, then ordered drain
        cycle(1'b1, mk(32'hA, 1'b1, 1'b0, 1'b0, 5'd1), 1'b0, 1'b0);
        cycle(1'b1, mk(32'hB, 1'b0, 1'b1, 1'b1, 5'd2), 1'b0, 1'b0);
        cycle(1'b0, idle, 1'b0, 1'b0);
        cycle(1'b0, idle, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, idle, 1'b1, 1'b0);

        // Flush while full, with a new instruction presented
        cycle(1'b1, mk(32'hA1, 1'b1, 1'b0, 1'b0, 5'd1), 1'b0, 1'b0);
        cycle(1'b1, mk(32'hB1, 1'b1, 1'b0, 1'b0, 5'd2), 1'b0, 1'b0);
        cycle(1'b1, mk(32'hC, 1'b1, 1'b0, 1'b1, 5'd3), 1'b0, 1'b1);
        cycle(1'b0, idle, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);

        // x0 write suppression
        cycle(1'b1, mk(32'h50, 1'b0, 1'b0, 1'b1, 5'd0), 1'b0, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        cycle(1'b1, mk(32'h55, 1'b0, 1'b0, 1'b1, 5'd5), 1'b0, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);

        // Single-register build: stall then replace-in-place
        cycle(1'b1, mk(32'h60, 1'b0, 1'b0, 1'b1, 5'd7), 1'b0, 1'b0);
        cycle(1'b0, idle, 1'b0, 1'b0);
        cycle(1'b1, mk(32'h61, 1'b0, 1'b0, 1'b1, 5'd8), 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);

        // Reset asserted with entries in flight
        cycle(1'b1, mk(32'h70, 1'b1, 1'b0, 1'b0, 5'd1), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h71, 1'b1, 1'b0, 1'b0, 5'd2), 1'b0, 1'b0);
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        chk("midrst.mem_valid", 64'({mem_valid_1, mem_valid_0}), 64'(0));
        chk("midrst.occupancy", 64'({occ_1, occ_0}), 64'(0));
        chk("midrst.ex_ready", 64'(ex_ready_1), 64'(1));
        chk("midrst.load_type", 64'(mem_ld_1), 64'(3'b111));
        chk("midrst.mem_write", 64'(mem_write_1), 64'(0));
        exp_q[0].delete();
        exp_q[1].delete();
        cycle(1'b0, idle, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with alternating light/heavy backpressure
        for (int i = 0; i < 3000; i++) begin
            if (((i / 150) % 2) == 1) mr_r = ($urandom_range(0, 3) == 0);
            else                      mr_r = ($urandom_range(0, 2) != 0);
            cycle(($urandom_range(0, 3) != 0), rnd_item(), mr_r, ($urandom_range(0, 49) == 0));
        end
        repeat (5) cycle(1'b0, idle, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid_pipeline.md
Name: ex_mem_skid_pipeline

Overview:
- Parametrised EX/MEM pipeline stage: the next generation of the plain EX/MEM register.
- Adds a valid/ready handshake on both sides, an optional 2-entry skid buffer that keeps ex_ready registered, flush-to-bubble, and x0 write suppression.
- Sits between the execute stage and data-memory/writeback.
- Lets the memory side stall, for example on a multi-cycle memory, without a combinational ready path back into EX.

Parameters:
- XLEN, 32, width of result and store-data fields
- RD_W, 5, destination register index width
- LD_W, 3, load-type field width
- ST_W, 2, store-type field width
- SKID, 1, 1 = 2-entry skid buffer (ex_ready registered); 0 = single register (ex_ready combinational)
- LD_TYPE_RST, 3'b111, reset and bubble value of mem_memory_load_type
- ST_TYPE_RST, 2'b11, reset and bubble value of mem_memory_store_type

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill all held entries
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  stage can accept
- ex_result  in  XLEN  ALU result / address
- ex_op2_selected  in  XLEN  store data
- ex_memory_write  in  1  store instruction
- ex_memory_load_type  in  LD_W  load size/sign
- ex_memory_store_type  in  ST_W  store size
- ex_wb_load  in  1  load instruction
- ex_wb_reg_file  in  1  writes register file
- ex_wb_rd  in  RD_W  destination register
- mem_valid  out  1  head entry valid
- mem_ready  in  1  MEM consumes head
- mem_result, mem_op2_selected  out  XLEN  head data
- mem_memory_write, mem_memory_read  out  1  gated strobes
- mem_memory_load_type  out  LD_W
- mem_memory_store_type  out  ST_W
- mem_wb_load, mem_wb_reg_file  out  1  gated
- mem_wb_rd  out  RD_W
- occupancy  out  2  entries held (0..2)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state EMPTY; mem_valid=0; occupancy=0
  - all data fields 0; load_type=LD_TYPE_RST; store_type=ST_TYPE_RST; all strobes 0
  - ex_ready=1 when SKID=1
- Transfer events:
  - accept = ex_valid & ex_ready
  - drain = mem_valid & mem_ready
- Storage: main register (the head, drives mem_*) and skid register (present only when SKID=1).
- States:
  - EMPTY
    - accept -> HALF, main<=ex
  - HALF
    - accept & drain -> HALF, main<=ex
    - accept & !drain -> FULL, skid<=ex
    - !accept & drain -> EMPTY
    - neither -> hold
  - FULL
    - drain -> HALF, main<=skid
    - else hold; accept is impossible because ex_ready=0
- ex_ready:
  - SKID=1: registered, = (next state != FULL)
  - SKID=0: FULL does not exist; ex_ready = !mem_valid | mem_ready (combinational)
- Latency: one cycle from accept to mem_valid when empty. Strict FIFO order; no entry is dropped or duplicated.
- Held head: while mem_valid & !mem_ready, all mem_* outputs are stable.
- Strobe gating:
  - mem_memory_write, mem_memory_read and mem_wb_load = stored bit & mem_valid
  - mem_wb_reg_file = stored bit & mem_valid & (mem_wb_rd != 0)
  - mem_memory_read mirrors the stored wb_load
- Bubble outputs: when mem_valid=0, load_type=LD_TYPE_RST and store_type=ST_TYPE_RST. Result, op2 and rd hold their last values.
- Flush:
  - Next state EMPTY and all valids cleared, regardless of accept/drain in the same cycle; flush wins, and the presented EX instruction is discarded.
  - ex_ready=1 the cycle after flush.
  - Data registers are not cleared.
- Simultaneous drain and accept in HALF keeps occupancy at 1 with no bubble, sustaining full throughput.
- occupancy = 0/1/2 for EMPTY/HALF/FULL, registered.
- Reset asserted mid-transfer: immediate return to reset values; in-flight entries are lost.

Decomposition:
- Shared package (pipeline_pkg):
  - reset constants LD_TYPE_RST and ST_TYPE_RST
  - state encoding EMPTY=2'd0, HALF=2'd1, FULL=2'd2
  - a packed ex_mem payload layout: result, op2, write, load_type, store_type, wb_load, wb_reg_file, rd
- One sub-module is natural: pipe_skid_reg, a generic WIDTH-bit 2-entry skid buffer with valid/ready.
  - The top level packs and unpacks the payload, and applies strobe gating, x0 suppression and bubble values.

Test Plan:
1. Reset with rst_n=0 -> mem_valid=0, load_type=3'b111, store_type=2'b11, strobes 0, occupancy=0, ex_ready=1.
2. Streaming: mem_ready=1, ex_valid=1, results 0x10, 0x20, 0x30 on consecutive cycles -> mem_result is 0x10, 0x20, 0x30 one cycle later, mem_valid=1 throughout, occupancy stays 1.
3. Backpressure (SKID=1):
   - Accept 0xA then 0xB with mem_ready=0 -> occupancy=2, ex_ready=0, mem_result holds 0xA.
   - Raise mem_ready -> 0xA then 0xB drain in order, and ex_ready returns to 1 one cycle after the first drain.
4. Flush in FULL with ex_valid=1 presenting 0xC -> next cycle mem_valid=0, occupancy=0, and mem_memory_write=0 even though a store was held; 0xC never appears at the output.
5. x0 suppression: accept rd=0 with wb_reg_file=1 -> mem_wb_reg_file=0 while mem_valid=1; accept rd=5 -> mem_wb_reg_file=1.
6. SKID=0 build, hold mem_ready=0 with one entry -> ex_ready=0 in the same cycle; pulse mem_ready=1 with ex_valid=1 -> replacement entry is accepted that cycle with no bubble.
